// File: rtl/dec_scan_ctrl.sv
// Display scan controller: walks a 3-bit decoder select across eight stored
// digits at a prescaled rate, with an optional enable-low gap between digits.
module dec_scan_ctrl #(
    parameter int unsigned PRESCALE  = 4,
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic [3:0] digit,
    output logic       frame_done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned DAT_W = 4;
    localparam int unsigned N_DIG = 8;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_MAX    = SEL_W'(N_DIG - 1);
    localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               HAS_BLANK  = (BLANK_CYC != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             sel_en_nxt;
    logic             frame_done_nxt;

    logic [DAT_W-1:0] mem [N_DIG];

    // Digit storage; cleared by reset, writable in any scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_DIG); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Value shown for the currently selected position.
    assign digit = mem[sel];

    // State, slot counter and registered decoder drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel        <= '0;
            sel_en     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            sel_en     <= sel_en_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Next-state logic; sel only moves while the enable is, or stays, safely
    // gated by the slot boundary so two decoder outputs never overlap.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sel_nxt        = sel;
        sel_en_nxt     = sel_en;
        frame_done_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                sel_en_nxt = 1'b0;
                cnt_nxt    = '0;
                if (run) begin
                    state_nxt  = ST_SHOW;
                    sel_en_nxt = 1'b1;
                end
            end

            ST_SHOW: begin
                if (!run) begin
                    state_nxt  = ST_IDLE;
                    sel_en_nxt = 1'b0;
                    cnt_nxt    = '0;
                end else if (cnt == SHOW_LAST) begin
                    cnt_nxt = '0;
                    if (HAS_BLANK) begin
                        state_nxt  = ST_BLANK;
                        sel_en_nxt = 1'b0;
                    end else begin
                        sel_en_nxt     = 1'b1;
                        sel_nxt        = sel + SEL_ONE;
                        frame_done_nxt = (sel == SEL_MAX);
                    end
                end else begin
                    sel_en_nxt = 1'b1;
                    cnt_nxt    = cnt + CNT_ONE;
                end
            end

            ST_BLANK: begin
                sel_en_nxt = 1'b0;
                if (!run) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nxt      = ST_SHOW;
                    sel_en_nxt     = 1'b1;
                    cnt_nxt        = '0;
                    sel_nxt        = sel + SEL_ONE;
                    frame_done_nxt = (sel == SEL_MAX);
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                sel_en_nxt = 1'b0;
                cnt_nxt    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: a phase-based model predicts each cycle's outputs
// into a scoreboard queue that the scenario tasks pop and compare.
module tb_dec_scan_ctrl;

    localparam int unsigned P = 4;
    localparam int unsigned B = 1;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic [3:0] digit;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       run_b = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;

    logic [2:0] sel_a, sel_b;
    logic       en_a, en_b;
    logic [3:0] digit_a, digit_b;
    logic       fd_a, fd_b;

    int n_chk  = 0;
    int n_pass = 0;

    // model state for the P=4/B=1 instance
    logic       m_act;
    int         m_ph;
    logic [2:0] m_sel;
    logic       m_fd;
    logic [3:0] m_mem [8];
    exp_t       sb [$];

    dec_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) dut_a (
        .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .sel(sel_a), .sel_en(en_a), .digit(digit_a),
        .frame_done(fd_a)
    );

    dec_scan_ctrl #(.PRESCALE(1), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .run(run_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .sel(sel_b), .sel_en(en_b), .digit(digit_b),
        .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs_a();
        exp_t o;
        o = {sel_a, en_a, digit_a, fd_a};
        return o;
    endfunction

    task automatic model_reset();
        m_act = 1'b0;
        m_ph  = 0;
        m_sel = '0;
        m_fd  = 1'b0;
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        sb.delete();
    endtask

    // Advance the model by one rising edge and queue the expected outputs.
    task automatic model_edge();
        exp_t e;
        if (wr_en) m_mem[wr_addr] = wr_data;
        m_fd = 1'b0;
        if (!m_act) begin
            if (run) begin
                m_act = 1'b1;
                m_ph  = 0;
            end
        end else if (!run) begin
            m_act = 1'b0;
            m_ph  = 0;
        end else begin
            m_ph++;
            if (m_ph == int'(P + B)) begin
                m_ph  = 0;
                m_sel = m_sel + 3'd1;
                m_fd  = (m_sel == 3'd0);
            end
        end
        e.sel   = m_sel;
        e.en    = m_act && (m_ph < int'(P));
        e.digit = m_mem[m_sel];
        e.fd    = m_fd;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        exp_t g;
        model_reset();
        #2;
        g = obs_a();
        n_chk++;
        if (g !== '0) $display("FAIL reset_async got %h exp 0", g);
        else n_pass++;
        @(posedge clk);
        #1;
        g = obs_a();
        n_chk++;
        if (g !== '0) $display("FAIL reset_held got %h exp 0", g);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write();
        exp_t e, g;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 1);
            step();
            e = sb.pop_front();
            g = obs_a();
            n_chk++;
            if (g !== e) $display("FAIL write_idle i=%0d got %h exp %h", i, g, e);
            else n_pass++;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_scan();
        exp_t e, g;
        int fdcnt;
        fdcnt = 0;
        run = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            e = sb.pop_front();
            g = obs_a();
            if (g.fd) fdcnt++;
            n_chk++;
            if (g !== e) $display("FAIL scan k=%0d got %h exp %h", k, g, e);
            else n_pass++;
        end
        n_chk++;
        if (fdcnt != 2) $display("FAIL scan_frame_count got %0d exp 2", fdcnt);
        else n_pass++;
    endtask

    task automatic test_run_drop();
        exp_t e, g;
        int hi, k;
        k = 0;
        while (!(m_sel == 3'd3 && m_act && m_ph == 1) && k < 60) begin
            step();
            e = sb.pop_front();
            g = obs_a();
            n_chk++;
            if (g !== e) $display("FAIL drop_seek got %h exp %h", g, e);
            else n_pass++;
            k++;
        end
        n_chk++;
        if (k >= 60) $display("FAIL drop_seek_timeout got %0d exp <60", k);
        else n_pass++;
        run = 1'b0;
        step();
        e = sb.pop_front();
        g = obs_a();
        n_chk++;
        if (g.sel !== 3'd3 || g.en !== 1'b0 || g !== e)
            $display("FAIL drop_idle got %h exp sel=3 en=0 (%h)", g, e);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            e = sb.pop_front();
            g = obs_a();
            n_chk++;
            if (g !== e) $display("FAIL drop_hold got %h exp %h", g, e);
            else n_pass++;
        end
        run = 1'b1;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            e = sb.pop_front();
            g = obs_a();
            if (i < 4 && g.en === 1'b1 && g.sel === 3'd3) hi++;
            n_chk++;
            if (g !== e) $display("FAIL resume i=%0d got %h exp %h", i, g, e);
            else n_pass++;
        end
        n_chk++;
        if (hi != 4) $display("FAIL resume_slot got %0d exp 4", hi);
        else n_pass++;
        n_chk++;
        if (g.sel !== 3'd4) $display("FAIL resume_next got %0d exp 4", g.sel);
        else n_pass++;
    endtask

    task automatic test_write_live();
        exp_t e, g;
        int k;
        k = 0;
        while (!(m_sel == 3'd5 && m_act && m_ph < int'(P) - 1) && k < 60) begin
            step();
            e = sb.pop_front();
            g = obs_a();
            n_chk++;
            if (g !== e) $display("FAIL live_seek got %h exp %h", g, e);
            else n_pass++;
            k++;
        end
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_data = 4'hA;
        step();
        wr_en = 1'b0;
        e = sb.pop_front();
        g = obs_a();
        n_chk++;
        if (g.digit !== 4'hA || g.sel !== 3'd5 || g !== e)
            $display("FAIL live_write got %h exp digit=a (%h)", g, e);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step();
            e = sb.pop_front();
            g = obs_a();
            n_chk++;
            if (g !== e) $display("FAIL live_after i=%0d got %h exp %h", i, g, e);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e, g;
        int k;
        k = 0;
        while (m_sel != 3'd6 && k < 60) begin
            step();
            e = sb.pop_front();
            g = obs_a();
            n_chk++;
            if (g !== e) $display("FAIL areset_seek got %h exp %h", g, e);
            else n_pass++;
            k++;
        end
        n_chk++;
        if (sel_a !== 3'd6) $display("FAIL areset_pre got %0d exp 6", sel_a);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        g = obs_a();
        n_chk++;
        if (g !== '0) $display("FAIL areset_now got %h exp 0", g);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            e = sb.pop_front();
            g = obs_a();
            n_chk++;
            if (g !== e) $display("FAIL areset_restart i=%0d got %h exp %h", i, g, e);
            else n_pass++;
        end
    endtask

    task automatic test_fast();
        exp_t g, e;
        int fdcnt;
        fdcnt = 0;
        run   = 1'b0;
        run_b = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            void'(sb.pop_front());
            e.sel   = 3'((k - 1) % 8);
            e.en    = 1'b1;
            e.digit = m_mem[e.sel];
            e.fd    = (k > 1) && ((k - 1) % 8 == 0);
            g = {sel_b, en_b, digit_b, fd_b};
            if (g.fd) fdcnt++;
            n_chk++;
            if (g !== e) $display("FAIL fast k=%0d got %h exp %h", k, g, e);
            else n_pass++;
        end
        n_chk++;
        if (fdcnt != 2) $display("FAIL fast_frame_count got %0d exp 2", fdcnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_scan();
        test_run_drop();
        test_write_live();
        test_async_reset();
        test_fast();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
